spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 179 +++++++++++++++++
 tb/tb_spi_slave.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave, modes 0-3, oversampled by Clk, one-byte transmit holding register
module spi_slave (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       CPol,
    input  logic       CPha,
    input  logic       SCK,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MisoOe,
    input  logic [7:0] TxData,
    input  logic       TxLoad,
    output logic       TxReady,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       Busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state;
    state_t state_next;

    logic sck_s1, sck_s2, sck_s3;
    logic ss_s1, ss_s2, ss_s3;
    logic mosi_s1, mosi_s2;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold;
    logic       reload_pend;
    logic       skip_shift;
    logic       rx_done;

    logic sck_rise, sck_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge;
    logic ss_fall, ss_rise;
    logic start, stop, in_shift;
    logic do_sample, do_shift, reload, consume;

    // SCK synchronizer resets to the idle level so reset release never looks like an edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sck_s1  <= CPol;
            sck_s2  <= CPol;
            sck_s3  <= CPol;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= SCK;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            ss_s1   <= SS_n;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sck_rise    = sck_s2 & ~sck_s3;
    assign sck_fall    = ~sck_s2 & sck_s3;
    assign lead_edge   = CPol ? sck_fall : sck_rise;
    assign trail_edge  = CPol ? sck_rise : sck_fall;
    assign sample_edge = CPha ? trail_edge : lead_edge;
    assign shift_edge  = CPha ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_s2 & ss_s3;
    assign ss_rise     = ss_s2 & ~ss_s3;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_fall) state_next = SHIFT;
            SHIFT:   if (ss_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign start     = (state == IDLE) && ss_fall;
    assign stop      = (state == SHIFT) && ss_rise;
    assign in_shift  = (state == SHIFT) && !ss_rise;
    assign do_sample = in_shift && sample_edge;
    assign do_shift  = in_shift && shift_edge;
    assign reload    = do_shift && reload_pend;
    assign consume   = start || reload;

    // Receive path: bit counter, receive shift register and the delayed valid strobe.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            RxData   <= 8'h00;
            rx_done  <= 1'b0;
            RxValid  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            RxValid <= rx_done;
            if (start || stop) begin
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
            end else if (do_sample) begin
                rx_shift <= {rx_shift[6:0], mosi_s2};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    RxData  <= {rx_shift[6:0], mosi_s2};
                    rx_done <= 1'b1;
                end
            end
        end
    end

    // Transmit path. In CPha=1 the first leading edge of a byte only presents the MSB.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_shift    <= 8'h00;
            reload_pend <= 1'b0;
            skip_shift  <= 1'b0;
        end else begin
            if (stop) begin
                reload_pend <= 1'b0;
                skip_shift  <= 1'b0;
            end else if (start) begin
                tx_shift    <= TxReady ? 8'h00 : hold;
                reload_pend <= 1'b0;
                skip_shift  <= CPha;
            end else begin
                if (do_sample && bit_cnt == 3'd7) begin
                    reload_pend <= 1'b1;
                end
                if (do_shift) begin
                    if (reload_pend) begin
                        tx_shift    <= TxReady ? 8'h00 : hold;
                        reload_pend <= 1'b0;
                    end else if (skip_shift) begin
                        skip_shift <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // A load in the consuming cycle refills the holding register behind the departing byte.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hold    <= 8'h00;
            TxReady <= 1'b1;
        end else begin
            if (TxLoad && (TxReady || consume)) begin
                hold    <= TxData;
                TxReady <= 1'b0;
            end else if (consume) begin
                TxReady <= 1'b1;
            end
        end
    end

    assign Busy   = (state == SHIFT);
    assign MISO   = (state == SHIFT) ? tx_shift[7] : 1'b0;
    assign MisoOe = (state == SHIFT) && !ss_s2;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave
module tb_spi_slave;

    logic       Clk = 1'b0;
    logic       Rst_n, CPol, CPha, SCK, SS_n, MOSI;
    logic       MISO, MisoOe, TxLoad, TxReady, RxValid, Busy;
    logic [7:0] TxData, RxData;

    spi_slave dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .CPol   (CPol),
        .CPha   (CPha),
        .SCK    (SCK),
        .SS_n   (SS_n),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .MisoOe (MisoOe),
        .TxData (TxData),
        .TxLoad (TxLoad),
        .TxReady(TxReady),
        .RxData (RxData),
        .RxValid(RxValid),
        .Busy   (Busy)
    );

    localparam int H = 5;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       load;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t       tbl[4];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         rv_count = 0;
    int         rv_last_cyc = 0;
    int         s8_cyc = 0;
    logic [7:0] rx_q[$];

    // Reference: a one-entry holding slot drained at every byte start.
    bit         hold_full;
    logic [7:0] hold_val;
    logic [7:0] exp_miso;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        #1;
        if (RxValid === 1'b1) begin
            rv_count++;
            rx_q.push_back(RxData);
            rv_last_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge Clk);
        TxData = v;
        TxLoad = 1'b1;
        @(negedge Clk);
        TxLoad = 1'b0;
        if (!hold_full) begin
            hold_full = 1'b1;
            hold_val  = v;
        end
    endtask

    task automatic take_byte(output logic [7:0] e);
        e         = hold_full ? hold_val : 8'h00;
        hold_full = 1'b0;
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        @(negedge Clk);
        CPol = cpol;
        CPha = cpha;
        SCK  = cpol;
        repeat (4) @(negedge Clk);
    endtask

    task automatic ss_start();
        @(negedge Clk);
        SS_n = 1'b0;
        take_byte(exp_miso);
        rv_count = 0;
        rx_q.delete();
        repeat (6) @(negedge Clk);
    endtask

    task automatic ss_end();
        repeat (H) @(negedge Clk);
        SS_n = 1'b1;
        repeat (6) @(negedge Clk);
    endtask

    // Master side: MOSI/MISO MSB first, MISO read on the sample edge.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!CPha) begin
                MOSI = mo[7-i];
                repeat (H) @(negedge Clk);
                SCK = ~CPol;
                mi[7-i] = MISO;
                if (i == 7) s8_cyc = cyc + 1;
                repeat (H) @(negedge Clk);
                SCK = CPol;
            end else begin
                SCK  = ~CPol;
                MOSI = mo[7-i];
                repeat (H) @(negedge Clk);
                SCK = CPol;
                mi[7-i] = MISO;
                if (i == 7) s8_cyc = cyc + 1;
                repeat (H) @(negedge Clk);
            end
        end
    endtask

    task automatic run_byte(input logic [7:0] mo, output logic [7:0] got);
        ss_start();
        check("busy_shift", Busy, 1);
        check("miso_oe_shift", MisoOe, 1);
        check("tx_ready_after_ss", TxReady, 1);
        xfer(mo, 8, got);
        ss_end();
        check("miso_byte", got, exp_miso);
        check("rx_valid_count", rv_count, 1);
        check("rx_data", RxData, mo);
        check("rx_latency", rv_last_cyc, s8_cyc + 3);
        check("idle_busy", Busy, 0);
        check("idle_miso_oe", MisoOe, 0);
    endtask

    initial begin
        logic [7:0] got, got2, prev_rx, e2;

        tbl[0] = '{cpol: 1'b0, cpha: 1'b0, load: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5};
        tbl[1] = '{cpol: 1'b1, cpha: 1'b1, load: 1'b1, tx: 8'hC3, mosi: 8'h96, exp_miso: 8'hC3};
        tbl[2] = '{cpol: 1'b0, cpha: 1'b1, load: 1'b0, tx: 8'h77, mosi: 8'h5A, exp_miso: 8'h00};
        tbl[3] = '{cpol: 1'b1, cpha: 1'b0, load: 1'b1, tx: 8'hFF, mosi: 8'h01, exp_miso: 8'hFF};

        Rst_n = 1'b0; CPol = 1'b0; CPha = 1'b0; SCK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        TxData = 8'h00; TxLoad = 1'b0;
        hold_full = 1'b0; hold_val = 8'h00; exp_miso = 8'h00;
        repeat (3) @(negedge Clk);
        check("rst_miso", MISO, 0);
        check("rst_miso_oe", MisoOe, 0);
        check("rst_rx_data", RxData, 8'h00);
        check("rst_rx_valid", RxValid, 0);
        check("rst_busy", Busy, 0);
        check("rst_tx_ready", TxReady, 1);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        for (int v = 0; v < 4; v++) begin
            set_mode(tbl[v].cpol, tbl[v].cpha);
            if (tbl[v].load) load(tbl[v].tx);
            run_byte(tbl[v].mosi, got);
            check("table_miso", got, tbl[v].exp_miso);
        end

        // Mode 3, two bytes back to back, second byte loaded while the first is in flight.
        set_mode(1'b1, 1'b1);
        load(8'h81);
        ss_start();
        check("b2b_ready_start", TxReady, 1);
        load(8'h7E);
        check("b2b_ready_loaded", TxReady, 0);
        xfer(8'hC3, 8, got);
        take_byte(e2);
        xfer(8'h18, 8, got2);
        ss_end();
        check("b2b_miso0", got, 8'h81);
        check("b2b_miso1", got2, e2);
        check("b2b_rx_count", rv_count, 2);
        check("b2b_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hC3);
        check("b2b_rx1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h18);
        check("b2b_latency", rv_last_cyc, s8_cyc + 3);
        check("b2b_ready_end", TxReady, 1);

        // Abort after 5 bits.
        set_mode(1'b0, 1'b0);
        prev_rx = RxData;
        load(8'h99);
        ss_start();
        xfer(8'hFF, 5, got);
        ss_end();
        check("abort_partial_miso", got[7:3], 5'b10011);
        check("abort_no_valid", rv_count, 0);
        check("abort_rx_kept", RxData, prev_rx);
        run_byte(8'h55, got);

        // Reset in the middle of a byte.
        set_mode(1'b1, 1'b0);
        load(8'h3A);
        ss_start();
        xfer(8'hAA, 3, got);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("mid_rst_miso", MISO, 0);
        check("mid_rst_miso_oe", MisoOe, 0);
        check("mid_rst_rx_data", RxData, 8'h00);
        check("mid_rst_rx_valid", RxValid, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_tx_ready", TxReady, 1);
        SS_n = 1'b1;
        SCK  = CPol;
        hold_full = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk);
        check("post_rst_busy", Busy, 0);
        run_byte(8'hF0, got);

        // Second load while full is dropped.
        set_mode(1'b0, 1'b1);
        load(8'h11);
        check("dbl_ready_full", TxReady, 0);
        load(8'h22);
        run_byte(8'hE7, got);
        check("dbl_first_sent", got, 8'h11);
        run_byte(8'h3C, got);
        check("dbl_second_dropped", got, 8'h00);

        for (int r = 0; r < 16; r++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) load(8'($urandom_range(0, 255)));
            run_byte(8'($urandom_range(0, 255)), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
